spi_master_param: RTL and testbench

//   Parametrised SPI master for the flash interface: configurable word width, SCK divider
//   and all four SPI modes.

---
 rtl/spi_master_param.sv | 177 +++++++++++++++++
 tb/tb_spi_master_param.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// SPI master with configurable word width, SCK divider and all four SPI modes.
// Multi-word transactions keep cs_n low until a word flagged last has completed.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
    $error("spi_master_param: DATA_W must be in 2..32");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_param: CLK_DIV must be >= 1");
  end

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic                cpol_r;
  logic                cpha_r;
  logic                last_r;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sck      <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      last_r   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          sck <= cpol;
          if (tx_ready && tx_valid) begin
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            last_r   <= tx_last;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            div_cnt  <= '0;
            // CPHA=0 presents the MSB during SETUP; CPHA=1 shifts it out on the leading edge.
            if (!cpha) begin
              mosi  <= tx_data[DATA_W-1];
              tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
              tx_sr <= tx_data;
            end
            state <= S_SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        S_WAIT: begin
          if (tx_ready && tx_valid) begin
            last_r   <= tx_last;
            tx_ready <= 1'b0;
            div_cnt  <= '0;
            if (!cpha_r) begin
              mosi  <= tx_data[DATA_W-1];
              tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
              tx_sr <= tx_data;
            end
            state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_XFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 1'b1;
            // Even edges are leading; the sampling edge parity equals CPHA.
            if (edge_cnt[0] == cpha_r) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else begin
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (edge_cnt == EDGE_LAST) begin
              rx_data  <= cpha_r ? {rx_sr[DATA_W-2:0], miso} : rx_sr;
              rx_valid <= 1'b1;
              if (last_r) begin
                state <= S_HOLD;
              end else begin
                tx_ready <= 1'b1;
                state    <= S_WAIT;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            state   <= S_GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: behavioural SPI slave, vector table, random transactions
// and hand-written reset / back-to-back / wide-word sequences.
module tb_spi_master_param;

  localparam int DW   = 8;
  localparam int DIV  = 2;
  localparam int DWB  = 16;
  localparam int DIVB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          cpol_a, cpha_a, tx_last_a, tx_valid_a, tx_ready_a;
  logic          rx_valid_a, busy_a, sck_a, mosi_a, miso_a, cs_n_a;
  logic [DW-1:0] tx_data_a, rx_data_a;

  logic           cpol_b, cpha_b, tx_last_b, tx_valid_b, tx_ready_b;
  logic           rx_valid_b, busy_b, sck_b, mosi_b, miso_b, cs_n_b;
  logic [DWB-1:0] tx_data_b, rx_data_b;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(DIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpol(cpol_a), .cpha(cpha_a),
    .tx_data(tx_data_a), .tx_last(tx_last_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
    .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
  );

  spi_master_param #(.DATA_W(DWB), .CLK_DIV(DIVB)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpol(cpol_b), .cpha(cpha_b),
    .tx_data(tx_data_b), .tx_last(tx_last_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
    .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
  );

  assign miso_b = mosi_b;

  logic loop_a = 1'b0;
  logic miso_s = 1'b0;
  assign miso_a = loop_a ? mosi_a : miso_s;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave mode as programmed by the bench; deliberately independent of the DUT inputs.
  logic m_cpol = 1'b0;
  logic m_cpha = 1'b0;

  logic [7:0] slave_q[$];
  logic [7:0] slave_rx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] s_word = '0;
  logic [7:0] s_rcv  = '0;
  int         s_bits = 0;
  logic       s_active = 1'b0;
  logic       s_prev   = 1'b0;

  task automatic s_load();
    if (slave_q.size() > 0) s_word = slave_q.pop_front();
    else                    s_word = 8'h00;
  endtask

  always @(negedge clk) begin
    if (cs_n_a !== 1'b0) begin
      s_active = 1'b0;
      s_prev   = sck_a;
    end else if (!s_active) begin
      s_active = 1'b1;
      s_bits   = 0;
      s_prev   = sck_a;
      if (!m_cpha) begin
        s_load();
        miso_s = s_word[7];
      end
    end else begin
      if (sck_a !== s_prev) begin
        if (s_prev == m_cpol) begin
          if (m_cpha) begin
            if (s_bits == 0) s_load();
            miso_s = s_word[7-s_bits];
          end else begin
            s_rcv = {s_rcv[6:0], mosi_a};
          end
        end else begin
          if (m_cpha) s_rcv = {s_rcv[6:0], mosi_a};
          s_bits++;
          if (s_bits == 8) begin
            slave_rx_q.push_back(s_rcv);
            s_bits = 0;
            if (!m_cpha) begin
              s_load();
              miso_s = s_word[7];
            end
          end else if (!m_cpha) begin
            miso_s = s_word[7-s_bits];
          end
        end
      end
      s_prev = sck_a;
    end
  end

  int   a_rises = 0, a_low_run = 0, a_last_low = 0, a_hi_run = 0, a_last_hi = 0;
  int   a_cs_rises = 0, a_gap_ready = 0, a_gap_sck_bad = 0, a_acc = 0;
  logic a_prev_sck = 1'b0;

  always @(negedge clk) begin
    if (cs_n_a === 1'b0 && sck_a === 1'b1 && a_prev_sck === 1'b0) a_rises++;
    a_prev_sck = sck_a;
    if (rx_valid_a === 1'b1) rx_q.push_back(rx_data_a);
    if (cs_n_a === 1'b0) begin
      a_low_run++;
      if (a_hi_run > 0) a_last_hi = a_hi_run;
      a_hi_run = 0;
    end else begin
      if (a_low_run > 0) begin
        a_last_low = a_low_run;
        a_cs_rises++;
      end
      a_low_run = 0;
      a_hi_run++;
    end
    if (busy_a === 1'b1 && cs_n_a === 1'b1 && tx_ready_a === 1'b1) a_gap_ready++;
    if (busy_a === 1'b1 && cs_n_a === 1'b1 && sck_a !== m_cpol) a_gap_sck_bad++;
  end

  always @(posedge clk) begin
    if (tx_valid_a === 1'b1 && tx_ready_a === 1'b1) a_acc++;
  end

  int             b_low_run = 0, b_word_len = 0, b_rxn = 0;
  logic [DWB-1:0] b_rx = '0;

  always @(negedge clk) begin
    if (rx_valid_b === 1'b1) begin
      b_rx       = rx_data_b;
      b_rxn++;
      b_word_len = b_low_run;
    end
    if (cs_n_b === 1'b0) b_low_run++;
    else                 b_low_run = 0;
  end

  typedef struct packed {
    logic            pol;
    logic            pha;
    logic            lp;
    logic            flip;
    logic [2:0]      n;
    logic [3:0][7:0] tw;
    logic [3:0][7:0] sw;
    logic [3:0][7:0] exp_rx;
  } vec_t;

  task automatic send_a(input logic [7:0] d, input logic last, output logic ok);
    logic rdy;
    int   n;
    n  = 0;
    ok = 1'b0;
    tx_data_a  = d;
    tx_last_a  = last;
    tx_valid_a = 1'b1;
    while (n < 200) begin
      rdy = tx_ready_a;
      tick();
      n++;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 2000) begin
      tick();
      n++;
      if (busy_a === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_a(input vec_t v, input string tag);
    logic ok;
    int   r0, c0, n;
    n = int'(v.n);
    cpol_a = v.pol;
    cpha_a = v.pha;
    m_cpol = v.pol;
    m_cpha = v.pha;
    loop_a = v.lp;
    slave_q.delete();
    for (int i = 0; i < 4; i++) slave_q.push_back(v.sw[i]);
    slave_rx_q.delete();
    rx_q.delete();
    tick();
    tick();
    check($sformatf("%s idle sck before", tag), sck_a, v.pol);
    r0 = a_rises;
    c0 = a_cs_rises;
    for (int i = 0; i < n; i++) begin
      send_a(v.tw[i], i == n - 1, ok);
      check($sformatf("%s accept%0d", tag, i), ok, 1);
      if (i == 0 && v.flip) begin
        cpol_a = ~v.pol;
        cpha_a = ~v.pha;
      end
    end
    wait_idle_a(ok);
    check($sformatf("%s done", tag), ok, 1);
    check($sformatf("%s rx count", tag), rx_q.size(), n);
    check($sformatf("%s slave count", tag), slave_rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) check($sformatf("%s rx[%0d]", tag, i), rx_q[i], v.exp_rx[i]);
      if (i < slave_rx_q.size()) check($sformatf("%s slave[%0d]", tag, i), slave_rx_q[i], v.tw[i]);
    end
    check($sformatf("%s sck rises", tag), a_rises - r0, 8 * n);
    check($sformatf("%s cs rises", tag), a_cs_rises - c0, 1);
    if (n == 1) check($sformatf("%s cs low cycles", tag), a_last_low, DIV * (1 + 2 * DW) + DIV);
    cpol_a = v.pol;
    cpha_a = v.pha;
    tick();
    tick();
    check($sformatf("%s idle sck after", tag), sck_a, v.pol);
  endtask

  task automatic run_b(input logic pol, input logic pha, input logic [15:0] d, input string tag);
    logic ok, rdy;
    int   n, rx0;
    cpol_b = pol;
    cpha_b = pha;
    tick();
    tick();
    rx0 = b_rxn;
    tx_data_b  = d;
    tx_last_b  = 1'b1;
    tx_valid_b = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 200) begin
      rdy = tx_ready_b;
      tick();
      n++;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tx_valid_b = 1'b0;
    check($sformatf("%s accept", tag), ok, 1);
    n  = 0;
    ok = 1'b0;
    while (n < 500) begin
      tick();
      n++;
      if (busy_b === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("%s done", tag), ok, 1);
    check($sformatf("%s rx count", tag), b_rxn - rx0, 1);
    check($sformatf("%s rx data", tag), b_rx, d);
    check($sformatf("%s word cycles", tag), b_word_len, DIVB * (1 + 2 * DWB));
  endtask

  vec_t vec[6];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic prev;
    int   e, n, acc0, rxn;

    // word lists run last-to-first: {w3, w2, w1, w0}
    vec[0] = '{pol:0, pha:0, lp:1, flip:0, n:1, tw:{24'h0, 8'hA5},
               sw:'0, exp_rx:{24'h0, 8'hA5}};
    vec[1] = '{pol:1, pha:1, lp:0, flip:0, n:1, tw:{24'h0, 8'hC3},
               sw:{24'h0, 8'h3C}, exp_rx:{24'h0, 8'h3C}};
    vec[2] = '{pol:0, pha:0, lp:0, flip:0, n:4, tw:{8'h00, 8'h00, 8'h00, 8'h9F},
               sw:{8'h18, 8'h40, 8'hEF, 8'h00}, exp_rx:{8'h18, 8'h40, 8'hEF, 8'h00}};
    vec[3] = '{pol:0, pha:1, lp:0, flip:1, n:1, tw:{24'h0, 8'h12},
               sw:{24'h0, 8'h81}, exp_rx:{24'h0, 8'h81}};
    vec[4] = '{pol:1, pha:0, lp:0, flip:1, n:2, tw:{16'h0, 8'hFF, 8'h00},
               sw:{16'h0, 8'h01, 8'hFF}, exp_rx:{16'h0, 8'h01, 8'hFF}};
    vec[5] = '{pol:1, pha:1, lp:1, flip:0, n:3, tw:{8'h0, 8'h7E, 8'h80, 8'h01},
               sw:'0, exp_rx:{8'h0, 8'h7E, 8'h80, 8'h01}};

    rst_n = 1'b0;
    cpol_a = 1'b1; cpha_a = 1'b0; tx_data_a = '0; tx_last_a = 1'b0; tx_valid_a = 1'b0;
    cpol_b = 1'b0; cpha_b = 1'b0; tx_data_b = '0; tx_last_b = 1'b0; tx_valid_b = 1'b0;
    repeat (3) tick();
    check("reset sck", sck_a, 0);
    check("reset cs_n", cs_n_a, 1);
    check("reset mosi", mosi_a, 0);
    check("reset rx_data", rx_data_a, 0);
    check("reset rx_valid", rx_valid_a, 0);
    check("reset busy", busy_a, 0);
    check("reset tx_ready", tx_ready_a, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle sck follows cpol", sck_a, 1);
    check("idle tx_ready", tx_ready_a, 1);
    check("idle cs_n", cs_n_a, 1);

    for (int i = 0; i < 6; i++) run_a(vec[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      v      = '0;
      v.pol  = 1'($urandom_range(0, 1));
      v.pha  = 1'($urandom_range(0, 1));
      v.lp   = 1'($urandom_range(0, 1));
      v.flip = 1'($urandom_range(0, 1));
      v.n    = 3'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        v.tw[k]     = 8'($urandom);
        v.sw[k]     = 8'($urandom);
        v.exp_rx[k] = v.lp ? v.tw[k] : v.sw[k];
      end
      run_a(v, $sformatf("rnd%0d", i));
    end

    // Reset at the 5th SCK edge of a mode-2 word: sck must drop to 0, not idle high.
    m_cpol = 1'b1; m_cpha = 1'b0; cpol_a = 1'b1; cpha_a = 1'b0; loop_a = 1'b1;
    rx_q.delete();
    tick();
    send_a(8'hF0, 1'b1, ok);
    check("rst accept", ok, 1);
    prev = sck_a;
    e = 0;
    n = 0;
    while (e < 5 && n < 500) begin
      tick();
      n++;
      if (sck_a !== prev) e++;
      prev = sck_a;
    end
    check("rst edges reached", e, 5);
    rst_n = 1'b0;
    tick();
    check("rst cs_n", cs_n_a, 1);
    check("rst sck", sck_a, 0);
    check("rst busy", busy_a, 0);
    check("rst rx_valid", rx_valid_a, 0);
    rst_n = 1'b1;
    rxn = rx_q.size();
    repeat (40) tick();
    check("rst no rx_valid", rx_q.size(), rxn);
    v = '{pol:0, pha:0, lp:1, flip:0, n:1, tw:{24'h0, 8'h3C}, sw:'0, exp_rx:{24'h0, 8'h3C}};
    run_a(v, "post_rst");

    // Back-to-back last words with tx_valid held high.
    m_cpol = 1'b0; m_cpha = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; loop_a = 1'b1;
    rx_q.delete();
    tick();
    acc0 = a_acc;
    tx_data_a  = 8'h5A;
    tx_last_a  = 1'b1;
    tx_valid_a = 1'b1;
    n = 0;
    while (a_acc < acc0 + 2 && n < 500) begin
      tick();
      n++;
    end
    tx_valid_a = 1'b0;
    check("b2b accepts", a_acc - acc0, 2);
    wait_idle_a(ok);
    check("b2b done", ok, 1);
    check("b2b rx count", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      check("b2b rx0", rx_q[0], 8'h5A);
      check("b2b rx1", rx_q[1], 8'h5A);
    end
    check("b2b cs high gap", a_last_hi, DIV + 1);
    check("gap tx_ready low", a_gap_ready, 0);
    check("gap sck idle", a_gap_sck_bad, 0);

    run_b(1'b0, 1'b1, 16'hBEEF, "w16 mode1");
    run_b(1'b1, 1'b0, 16'hBEEF, "w16 mode2");
    run_b(1'b1, 1'b1, 16'($urandom), "w16 mode3 rnd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
